// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame sequencer for the bouncing-ball sprite.
// Detects the start of vertical blank from the vgaDriver row feed, steps the
// ball one axis per cycle (horizontal, then vertical), reflects it off the
// screen edges and flags pixels that fall inside the ball for the RGB mux.
// Optional feature: define BALL_SPEEDUP_EN to make every reflection add one
// pixel/frame to that axis speed, saturating at MAX_SPEED.
module ball_motion_ctrl #(
  parameter int POS_W      = 16,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BALL_SIZE  = 4,
  parameter int H_INIT     = 128,
  parameter int V_INIT     = 128,
  parameter int INIT_SPEED = 2,
  parameter int MAX_SPEED  = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [POS_W-1:0] row_i,
  input  logic [POS_W-1:0] column_i,
  output logic [POS_W-1:0] ball_hpos_o,
  output logic [POS_W-1:0] ball_vpos_o,
  output logic             ball_on_o,
  output logic             bounce_h_o,
  output logic             bounce_v_o
);

  // Speed registers are sized for the ceiling so both builds share one datapath.
  localparam int SPD_W = $clog2(MAX_SPEED + 1);

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   ext_t;   // one guard bit: edge tests never wrap
  typedef logic [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP_H = 2'd1,
    S_STEP_V = 2'd2
  } state_e;

  typedef struct packed {
    pos_t pos;
    logic dir;
    logic bounce;
  } step_t;

  // Direction encoding: 1 = towards larger coordinates (right / down).
  localparam logic DIR_NEG = 1'b0;
  localparam logic DIR_POS = 1'b1;

  localparam pos_t H_MAXP    = pos_t'(H_ACTIVE - BALL_SIZE);
  localparam pos_t V_MAXP    = pos_t'(V_ACTIVE - BALL_SIZE);
  localparam pos_t VBLANK    = pos_t'(V_ACTIVE);
  localparam ext_t BALL_EXT  = ext_t'(BALL_SIZE);
  localparam spd_t SPD_INIT  = spd_t'(INIT_SPEED);

  // One axis of motion: move by spd, clamp to [0, maxp] and reflect on contact.
  function automatic step_t axis_step(input pos_t pos, input logic dir,
                                      input spd_t spd, input pos_t maxp);
    ext_t  pos_x;
    ext_t  spd_x;
    ext_t  maxp_x;
    step_t r;
    pos_x    = {1'b0, pos};
    spd_x    = ext_t'(spd);
    maxp_x   = {1'b0, maxp};
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir == DIR_NEG) begin
      if (pos_x <= spd_x) begin
        r.pos    = '0;
        r.dir    = DIR_POS;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos - pos_t'(spd);
      end
    end else begin
      if (pos_x + spd_x >= maxp_x) begin
        r.pos    = maxp;
        r.dir    = DIR_NEG;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos + pos_t'(spd);
      end
    end
    return r;
  endfunction

`ifdef BALL_SPEEDUP_EN
  // Saturating +1 used after a reflection.
  function automatic spd_t speed_bump(input spd_t s);
    return (s >= spd_t'(MAX_SPEED)) ? s : s + spd_t'(1);
  endfunction
`endif

  state_e state_q, state_d;
  pos_t   hpos_q, hpos_d;
  pos_t   vpos_q, vpos_d;
  logic   h_dir_q, h_dir_d;
  logic   v_dir_q, v_dir_d;
  spd_t   h_spd_q, h_spd_d;
  spd_t   v_spd_q, v_spd_d;
  pos_t   row_prev_q, row_prev_d;
  logic   ball_on_q, ball_on_d;
  logic   bounce_h_q, bounce_h_d;
  logic   bounce_v_q, bounce_v_d;

  logic   frame_tick;
  step_t  h_step;
  step_t  v_step;
  ext_t   col_x, row_x, hpos_x, vpos_x;

  // Frame tick marks the first cycle of vertical blank.
  assign frame_tick = (row_i == VBLANK) && (row_prev_q != VBLANK);

  // Next-state logic: sequencer, axis updates and pixel hit test.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    h_dir_d    = h_dir_q;
    v_dir_d    = v_dir_q;
    h_spd_d    = h_spd_q;
    v_spd_d    = v_spd_q;
    bounce_h_d = 1'b0;
    bounce_v_d = 1'b0;
    row_prev_d = row_i;

    h_step = axis_step(hpos_q, h_dir_q, h_spd_q, H_MAXP);
    v_step = axis_step(vpos_q, v_dir_q, v_spd_q, V_MAXP);

    case (state_q)
      S_IDLE: begin
        if (frame_tick && enable_i) state_d = S_STEP_H;
      end
      S_STEP_H: begin
        hpos_d     = h_step.pos;
        h_dir_d    = h_step.dir;
        bounce_h_d = h_step.bounce;
`ifdef BALL_SPEEDUP_EN
        if (h_step.bounce) h_spd_d = speed_bump(h_spd_q);
`endif
        state_d    = S_STEP_V;
      end
      S_STEP_V: begin
        vpos_d     = v_step.pos;
        v_dir_d    = v_step.dir;
        bounce_v_d = v_step.bounce;
`ifdef BALL_SPEEDUP_EN
        if (v_step.bounce) v_spd_d = speed_bump(v_spd_q);
`endif
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    col_x     = {1'b0, column_i};
    row_x     = {1'b0, row_i};
    hpos_x    = {1'b0, hpos_q};
    vpos_x    = {1'b0, vpos_q};
    ball_on_d = (col_x >= hpos_x) && (col_x < hpos_x + BALL_EXT) &&
                (row_x >= vpos_x) && (row_x < vpos_x + BALL_EXT);
  end

  // State and registered outputs, cleared asynchronously by reset_i.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: state flops use non-blocking assignments so all of them update together from pre-edge values.
    if (reset_i) begin
      state_q    <= S_IDLE;
      hpos_q     <= pos_t'(H_INIT);
      vpos_q     <= pos_t'(V_INIT);
      h_dir_q    <= DIR_NEG;
      v_dir_q    <= DIR_POS;
      h_spd_q    <= SPD_INIT;
      v_spd_q    <= SPD_INIT;
      row_prev_q <= '0;
      ball_on_q  <= 1'b0;
      bounce_h_q <= 1'b0;
      bounce_v_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      h_dir_q    <= h_dir_d;
      v_dir_q    <= v_dir_d;
      h_spd_q    <= h_spd_d;
      v_spd_q    <= v_spd_d;
      row_prev_q <= row_prev_d;
      ball_on_q  <= ball_on_d;
      bounce_h_q <= bounce_h_d;
      bounce_v_q <= bounce_v_d;
    end
  end

  assign ball_hpos_o = hpos_q;
  assign ball_vpos_o = vpos_q;
  assign ball_on_o   = ball_on_q;
  assign bounce_h_o  = bounce_h_q;
  assign bounce_v_o  = bounce_v_q;

endmodule
